// File: rtl/alu4_arbiter.sv
// alu4_arbiter: shares one external 4-bit signed ALU between two requesters.
// The requesters are arbitrated round-robin. The winner's operands are latched
// and held on the ALU for HOLD_CYCLES. The result and flags are registered and
// returned on one response channel, tagged with the requester id.
// Optional feature macro: ALU_ARB_PERF_EN adds per-requester completion counters.
//
// Handshake semantics (all channels): a transfer happens on a rising clock edge
// where valid && ready are both high. A requester keeps valid and its payload
// stable until it sees ready. Once the response channel raises rsp_valid, it
// holds rsp_valid and rsp_* stable until rsp_ready is seen.
module alu4_arbiter #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [2:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [2:0] req1_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_ctrl,
  input  logic [3:0] alu_result,
  input  logic [3:0] alu_nzcv,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_result,
  output logic [3:0] rsp_nzcv,
`ifdef ALU_ARB_PERF_EN
  output logic [7:0] perf_cnt0,
  output logic [7:0] perf_cnt1,
`endif
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic       last_grant_q;
  logic       id_q;
  logic [3:0] a_q, b_q;
  logic [2:0] op_q;
  logic [3:0] cnt_q;
  logic       grant_id;
  logic       accept;
  logic       exec_done;
  logic       arith_op;

  // State register; reset always returns to IDLE
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, arbitration and ready generation
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant_id   = 1'b0;
    accept     = 1'b0;
    exec_done  = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time goes first
        if (req0_valid && req1_valid) grant_id = ~last_grant_q;
        else if (req1_valid)          grant_id = 1'b1;
        else                          grant_id = 1'b0;
        accept     = req0_valid || req1_valid;
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        if (cnt_q == HOLD_LAST) begin
          exec_done = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Only add and sub produce meaningful carry/overflow from the ALU
  assign arith_op = (op_q == 3'b000) || (op_q == 3'b001);

  // Operand latch, hold counter, round-robin pointer and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      a_q          <= 4'd0;
      b_q          <= 4'd0;
      op_q         <= 3'd0;
      cnt_q        <= 4'd0;
      rsp_id       <= 1'b0;
      rsp_result   <= 4'd0;
      rsp_nzcv     <= 4'd0;
    end else begin
      if (accept) begin
        a_q          <= grant_id ? req1_a  : req0_a;
        b_q          <= grant_id ? req1_b  : req0_b;
        op_q         <= grant_id ? req1_op : req0_op;
        id_q         <= grant_id;
        last_grant_q <= grant_id;
        cnt_q        <= 4'd0;
      end else if (state_q == EXEC) begin
        cnt_q <= cnt_q + 4'd1;
      end
      if (exec_done) begin
        rsp_id     <= id_q;
        rsp_result <= alu_result;
        rsp_nzcv   <= arith_op ? alu_nzcv : {alu_nzcv[3:2], 2'b00};
      end
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_ctrl  = op_q;
  assign rsp_valid = (state_q == RESP);
  assign dbg_state = state_q;

`ifdef ALU_ARB_PERF_EN
  // Saturating count of completed responses per requester
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt0 <= 8'd0;
      perf_cnt1 <= 8'd0;
    end else if (rsp_valid && rsp_ready) begin
      if (!rsp_id && perf_cnt0 != 8'hFF) perf_cnt0 <= perf_cnt0 + 8'd1;
      if (rsp_id && perf_cnt1 != 8'hFF)  perf_cnt1 <= perf_cnt1 + 8'd1;
    end
  end
`else
`endif

endmodule
